// File: rtl/if_stage_pkg.sv
// Shared widths, encodings and bus layouts for the instruction-fetch stage.
// Decode imports the same package so both ends agree on the redirect and fetch buses.
package if_stage_pkg;

  localparam int unsigned STALL_BUS_WD = 6;
  localparam int unsigned BR_WD        = 33;
  localparam int unsigned IF_TO_ID_WD  = 33;
  localparam int unsigned STALL_IF_BIT = 0;

  localparam logic        STOP     = 1'b1;
  localparam logic        NO_STOP  = 1'b0;
  localparam logic [31:0] RESET_PC = 32'hBFBF_FFFC;
  localparam logic [31:0] PC_STEP  = 32'd4;

  typedef struct packed {
    logic        br_e;
    logic [31:0] br_addr;
  } br_bus_t;

  typedef struct packed {
    logic        ce;
    logic [31:0] pc;
  } if_to_id_t;

  // A live redirect beats a parked one; otherwise fall through sequentially (wraps mod 2^32).
  function automatic logic [31:0] next_pc(input br_bus_t br, input logic pend_v,
                                          input logic [31:0] pend_addr, input logic [31:0] pc);
    logic [31:0] npc;
    if (br.br_e) begin
      npc = br.br_addr;
    end else if (pend_v) begin
      npc = pend_addr;
    end else begin
      npc = pc + PC_STEP;
    end
    return npc;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus bundle: stall/redirect inputs, decode slot and instruction SRAM port.
// The master side is the fetch stage; the slave side is the pipeline/SRAM environment.
interface if_stage_if;
  import if_stage_pkg::*;

  logic [STALL_BUS_WD-1:0] stall;
  br_bus_t                 br_bus;
  if_to_id_t               if_to_id_bus;
  logic                    inst_sram_en;
  logic [3:0]              inst_sram_wen;
  logic [31:0]             inst_sram_addr;
  logic [31:0]             inst_sram_wdata;

  modport master (
    input  stall,
    input  br_bus,
    output if_to_id_bus,
    output inst_sram_en,
    output inst_sram_wen,
    output inst_sram_addr,
    output inst_sram_wdata
  );

  modport slave (
    output stall,
    output br_bus,
    input  if_to_id_bus,
    input  inst_sram_en,
    input  inst_sram_wen,
    input  inst_sram_addr,
    input  inst_sram_wdata
  );

endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC mux and a one-entry parked redirect
// that remembers a branch target seen while the stage is stalled.
module if_stage
  import if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  if_stage_if.master  bus
);

  logic [31:0] pc_r;
  logic        ce_r;
  logic        pend_v_r;
  logic [31:0] pend_addr_r;

  logic [31:0] pc_nxt_s;
  logic        ce_nxt_s;
  logic        pend_v_nxt_s;
  logic [31:0] pend_addr_nxt_s;
  logic        stop_s;

  assign stop_s = (bus.stall[STALL_IF_BIT] == STOP);

  // Next-state: advance when free, otherwise hold the PC and park any redirect (last one wins).
  always_comb begin
    pc_nxt_s        = pc_r;
    ce_nxt_s        = ce_r;
    pend_v_nxt_s    = pend_v_r;
    pend_addr_nxt_s = pend_addr_r;
    if (!stop_s) begin
      pc_nxt_s     = next_pc(bus.br_bus, pend_v_r, pend_addr_r, pc_r);
      ce_nxt_s     = 1'b1;
      pend_v_nxt_s = 1'b0;
    end else if (bus.br_bus.br_e) begin
      pend_v_nxt_s    = 1'b1;
      pend_addr_nxt_s = bus.br_bus.br_addr;
    end else begin
      pend_v_nxt_s    = pend_v_r;
      pend_addr_nxt_s = pend_addr_r;
    end
  end

  // State register; reset parks the PC one word before the boot vector and drops any redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r        <= RESET_PC;
      ce_r        <= 1'b0;
      pend_v_r    <= 1'b0;
      pend_addr_r <= 32'h0000_0000;
    end else begin
      pc_r        <= pc_nxt_s;
      ce_r        <= ce_nxt_s;
      pend_v_r    <= pend_v_nxt_s;
      pend_addr_r <= pend_addr_nxt_s;
    end
  end

  // The SRAM sees the PC register directly so data returns while decode holds that PC.
  assign bus.inst_sram_en    = ce_r;
  assign bus.inst_sram_addr  = pc_r;
  assign bus.inst_sram_wen   = 4'b0000;
  assign bus.inst_sram_wdata = 32'h0000_0000;
  assign bus.if_to_id_bus    = '{ce: ce_r, pc: pc_r};

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: stimulus pushes the expected post-edge fetch slot,
// a monitor pops and compares one entry after every rising edge.
module tb_if_stage;
  import if_stage_pkg::*;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  if_stage_if bus ();

  if_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  typedef struct {
    logic        ce;
    logic [31:0] pc;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: the slot is checked just after each edge, against the oldest queued expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({e.name, ".bus"},  64'(bus.if_to_id_bus), {31'd0, e.ce, e.pc});
      check({e.name, ".en"},   64'(bus.inst_sram_en), 64'(e.ce));
      check({e.name, ".addr"}, 64'(bus.inst_sram_addr), 64'(e.pc));
      check({e.name, ".wen"},  64'(bus.inst_sram_wen), 64'd0);
      check({e.name, ".wdat"}, 64'(bus.inst_sram_wdata), 64'd0);
    end
  end

  task automatic step(input string name, input logic r, input logic st, input logic be,
                      input logic [31:0] ba, input logic ece, input logic [31:0] epc);
    exp_t e;
    @(negedge clk);
    rst               = r;
    bus.stall         = {5'b0, st};
    bus.br_bus.br_e   = be;
    bus.br_bus.br_addr = ba;
    e.ce   = ece;
    e.pc   = epc;
    e.name = name;
    exp_q.push_back(e);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.stall  = '0;
    bus.br_bus = '0;

    // Reset, including reset ignoring stall and a redirect request
    step("rst0",     1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'hBFBF_FFFC);
    step("rst_ign",  1'b1, 1'b1, 1'b1, 32'h1111_1110, 1'b0, 32'hBFBF_FFFC);
    // Sequential fetch from the boot vector
    step("seq0",     1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'hBFC0_0000);
    step("seq1",     1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'hBFC0_0004);
    step("seq2",     1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'hBFC0_0008);
    // Redirect seen at 0008: one-cycle latency, 0008 not refetched
    step("br_0100",  1'b0, 1'b0, 1'b1, 32'hBFC0_0100, 1'b1, 32'hBFC0_0100);
    step("post_br",  1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'hBFC0_0104);
    step("br_000c",  1'b0, 1'b0, 1'b1, 32'hBFC0_000C, 1'b1, 32'hBFC0_000C);
    step("to_0010",  1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'hBFC0_0010);
    // Three-cycle stall holds address with en=1
    step("stall1",   1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'hBFC0_0010);
    step("stall2",   1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'hBFC0_0010);
    step("stall3",   1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'hBFC0_0010);
    step("release",  1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'hBFC0_0014);
    // Redirect pulse during stall is parked and taken on release
    step("pend_set", 1'b0, 1'b1, 1'b1, 32'hBFC0_0200, 1'b1, 32'hBFC0_0014);
    step("pend_hld", 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'hBFC0_0014);
    step("pend_use", 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'hBFC0_0200);
    step("pend_clr", 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'hBFC0_0204);
    // Second redirect within the same stall overwrites the first
    step("ovr_a",    1'b0, 1'b1, 1'b1, 32'hBFC0_0400, 1'b1, 32'hBFC0_0204);
    step("ovr_b",    1'b0, 1'b1, 1'b1, 32'hBFC0_0500, 1'b1, 32'hBFC0_0204);
    step("ovr_use",  1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'hBFC0_0500);
    // Live redirect on release beats the parked one, and the parked one is dropped
    step("pri_pend", 1'b0, 1'b1, 1'b1, 32'hBFC0_0200, 1'b1, 32'hBFC0_0500);
    step("pri_live", 1'b0, 1'b0, 1'b1, 32'hBFC0_0300, 1'b1, 32'hBFC0_0300);
    step("pri_clr",  1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'hBFC0_0304);
    // PC wrap and unaligned target passed through untouched
    step("br_top",   1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC);
    step("wrap",     1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0000);
    step("unalign",  1'b0, 1'b0, 1'b1, 32'h0000_0003, 1'b1, 32'h0000_0003);
    step("unal_inc", 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0007);
    // Reset mid-stall with a parked redirect discards it; stall right after reset keeps en=0
    step("rp_pend",  1'b0, 1'b1, 1'b1, 32'h0000_1234, 1'b1, 32'h0000_0007);
    step("rp_rst",   1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'hBFBF_FFFC);
    step("rp_stall", 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'hBFBF_FFFC);
    step("rp_boot",  1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'hBFC0_0000);
    step("rp_next",  1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'hBFC0_0004);

    @(negedge clk);
    @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL have the port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port `rst`, input, 1 bit: reset, synchronous and active-high.
REQ-003 The block SHALL have the port `stall`, input, `StallBus bits: pipeline stall vector; bit 0 is the IF stall (`Stop=1, `NoStop=0).
REQ-004 The block SHALL have the port `br_bus`, input, `BR_WD (33) bits: {br_e, br_addr[31:0]}, the redirect request from the decode stage.
REQ-005 The block SHALL have the port `if_to_id_bus`, output, `IF_TO_ID_WD (33) bits: {ce, pc[31:0]}, the fetch slot handed to decode.
REQ-006 The block SHALL have the port `inst_sram_en`, output, 1 bit: instruction SRAM read enable.
REQ-007 The block SHALL have the port `inst_sram_wen`, output, 4 bits: instruction SRAM byte write enables, constant 4'b0000.
REQ-008 The block SHALL have the port `inst_sram_addr`, output, 32 bits: fetch address.
REQ-009 The block SHALL have the port `inst_sram_wdata`, output, 32 bits: constant 32'b0.

Function
REQ-010 State SHALL be: pc_r (32b), ce_r (1b), pend_v (1b), pend_addr (32b).
REQ-011 The block SHALL drive inst_sram_addr = pc_r and inst_sram_en = ce_r combinationally, so read data arrives in the cycle decode holds that pc.
REQ-012 The block SHALL drive if_to_id_bus = {ce_r, pc_r} combinationally.
REQ-013 The next-PC priority, when stall[0]==`NoStop, SHALL be: br_e ? br_addr : pend_v ? pend_addr : pc_r + 4.
REQ-014 When stall[0]==`NoStop, the block SHALL load pc_r with the next-PC, set ce_r to 1 and clear pend_v.
REQ-015 When stall[0]==`Stop, pc_r and ce_r SHALL hold; inst_sram_en stays ce_r, so the same address is re-read.
REQ-016 A br_e asserted while stall[0]==`Stop SHALL set pend_v=1 and pend_addr=br_addr; a later br_e during the same stall SHALL overwrite pend_addr.
REQ-017 If br_e and pend_v are both true on an unstalled cycle, br_addr SHALL win and pend_v SHALL clear.
REQ-018 The delay slot (the instruction at pc_r when br_e is seen) SHALL NOT be squashed; the redirect takes effect on the following fetch.
REQ-019 pc_r + 4 SHALL wrap modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
REQ-020 br_addr SHALL be used unmodified; there is no alignment checking in this block.
REQ-021 Redirect latency SHALL be 1 cycle: br_e in unstalled cycle t yields inst_sram_addr = br_addr in cycle t+1.

Reset
REQ-022 On rst=1 at a clock edge, the block SHALL set pc_r = 32'hBFBF_FFFC, ce_r = 0, pend_v = 0, pend_addr = 0; stall and br_bus are ignored.
REQ-023 During reset, the outputs SHALL be inst_sram_en=0 and if_to_id_bus={1'b0, 32'hBFBF_FFFC}.
REQ-024 The first unstalled edge after rst falls SHALL give pc_r=32'hBFC0_0000 and ce_r=1.
REQ-025 Reset asserted mid-stall with a pending redirect SHALL discard the redirect.

Structure
REQ-026 The widths StallBus, BR_WD and IF_TO_ID_WD, the encodings Stop/NoStop and the reset vector SHALL live in lib/defines.vh, shared with decode.
REQ-027 The block SHALL have no sub-module; the next-PC mux and the pending-redirect register are inline.

Verification
REQ-028 Reset then run with no stall -> inst_sram_addr = BFC0_0000, BFC0_0004, BFC0_0008 on consecutive cycles, with en=1.
REQ-029 br_e=1, br_addr=BFC0_0100 while pc_r=BFC0_0008 (unstalled) -> the next address is BFC0_0100, and BFC0_0008 is not repeated.
REQ-030 stall[0]=1 for 3 cycles at pc_r=BFC0_0010 -> the address holds at BFC0_0010 with en=1, then steps to BFC0_0014.
REQ-031 br_e pulse (addr BFC0_0200) during a 2-cycle stall, deasserted before release -> the first post-stall address is BFC0_0200.
REQ-032 Pending redirect BFC0_0200, then br_e=BFC0_0300 on the release cycle -> the next address is BFC0_0300 and pend_v=0.
REQ-033 rst pulse while pend_v=1 -> the first post-reset address is BFC0_0000.
